dsp_acc_tree: RTL and testbench

DSP_ACC_TREE -- requirements
Module: dsp_acc_tree

---
 rtl/dsp_pkg.sv | 20 ++
 rtl/dsp_add_stage.sv | 44 ++++
 rtl/dsp_acc_tree.sv | 129 ++++++++++++
 tb/tb_dsp_acc_tree.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP datapath widths, saturation limits and helpers
package dsp_pkg;

    localparam int LANES = 16;
    localparam int PW    = 11;
    localparam int ACCW  = 24;
    localparam int OW    = 16;

    localparam int SAT_MAX = (1 << (OW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OW - 1));

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // A group length of zero is meaningless; treat it as a single beat.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/dsp_add_stage.sv
// rtl/dsp_add_stage.sv - one registered pairwise adder level of the reduction tree
module dsp_add_stage #(
    parameter int N = 16,
    parameter int W = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [N*W-1:0]           in_data,
    output logic                     out_valid,
    output logic [(N/2)*(W+1)-1:0]   out_data
);

    logic                   valid_q;
    logic [(N/2)*(W+1)-1:0] sum_q;

    // Valid bit tracks whether the sums below hold a live beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= in_valid;
        end
    end

    // Sign-extend each operand by one bit so the pair sum cannot overflow.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < N / 2; i++) begin
                sum_q[i*(W+1) +: (W+1)] <=
                    {in_data[(2*i)*W + W - 1],   in_data[(2*i)*W +: W]} +
                    {in_data[(2*i+1)*W + W - 1], in_data[(2*i+1)*W +: W]};
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = sum_q;

endmodule

// File: rtl/dsp_acc_tree.sv
// rtl/dsp_acc_tree.sv - 16-lane adder tree with grouped accumulation and saturating output
module dsp_acc_tree #(
    parameter int LANES = dsp_pkg::LANES,
    parameter int PW    = dsp_pkg::PW,
    parameter int ACCW  = dsp_pkg::ACCW,
    parameter int OW    = dsp_pkg::OW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [7:0]          acc_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*PW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out_data,
    output logic                out_sat
);
    import dsp_pkg::*;

    localparam int W1 = PW + 1;
    localparam int W2 = PW + 2;
    localparam int W3 = PW + 3;
    localparam int TW = PW + 4;

    localparam logic signed [ACCW-1:0] SAT_HI_A = ACCW'(SAT_MAX);
    localparam logic signed [ACCW-1:0] SAT_LO_A = ACCW'(SAT_MIN);

    logic                    en;
    logic                    v1, v2, v3, v4;
    logic [(LANES/2)*W1-1:0] s1;
    logic [(LANES/4)*W2-1:0] s2;
    logic [(LANES/8)*W3-1:0] s3;
    logic [TW-1:0]           s4;

    logic [0:0]              state_q, state_d;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic signed [ACCW-1:0]  acc_q, acc_d, tree_ext, base, total;
    logic                    grp_end;
    logic [OW-1:0]           sat_data;
    logic                    sat_flag;
    logic                    out_valid_q, out_sat_q;
    logic [OW-1:0]           out_data_q;

    // Whole datapath freezes only while a finished result waits for the consumer.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    dsp_add_stage #(.N(LANES),   .W(PW)) u_stage1 (.clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
        .in_valid(in_valid), .in_data(in_data), .out_valid(v1), .out_data(s1));
    dsp_add_stage #(.N(LANES/2), .W(W1)) u_stage2 (.clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
        .in_valid(v1), .in_data(s1), .out_valid(v2), .out_data(s2));
    dsp_add_stage #(.N(LANES/4), .W(W2)) u_stage3 (.clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
        .in_valid(v2), .in_data(s2), .out_valid(v3), .out_data(s3));
    dsp_add_stage #(.N(LANES/8), .W(W3)) u_stage4 (.clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
        .in_valid(v3), .in_data(s3), .out_valid(v4), .out_data(s4));

    // Group sequencing: first tree output of a group loads, later ones add.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        grp_end  = 1'b0;
        tree_ext = {{(ACCW-TW){s4[TW-1]}}, s4};
        base     = (state_q == ST_FIRST) ? '0 : acc_q;
        total    = base + tree_ext;
        if (v4) begin
            acc_d = total;
            if (state_q == ST_FIRST) begin
                len_d   = eff_len(acc_len);
                cnt_d   = 8'd1;
                grp_end = (len_d == 8'd1);
            end else begin
                cnt_d   = cnt_q + 8'd1;
                grp_end = (cnt_d == len_q);
            end
            state_d = grp_end ? ST_FIRST : ST_ACCUM;
        end
    end

    // Clip the running group sum into the signed output range.
    always_comb begin
        sat_data = total[OW-1:0];
        sat_flag = 1'b0;
        if (total > SAT_HI_A) begin
            sat_data = SAT_HI_A[OW-1:0];
            sat_flag = 1'b1;
        end else if (total < SAT_LO_A) begin
            sat_data = SAT_LO_A[OW-1:0];
            sat_flag = 1'b1;
        end
    end

    // Accumulator, counter and result registers; clear wins over a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FIRST;
            len_q       <= 8'd1;
            cnt_q       <= 8'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_FIRST;
            cnt_q       <= 8'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= grp_end;
            if (grp_end) begin
                out_data_q <= sat_data;
                out_sat_q  <= sat_flag;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dsp_acc_tree.sv
// tb/tb_dsp_acc_tree.sv - randomized and directed bench for dsp_acc_tree against a group-sum model
module tb_dsp_acc_tree;

    localparam int LANES = 16;
    localparam int PW    = 11;
    localparam int OW    = 16;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b1;
    logic                clear     = 1'b0;
    logic [7:0]          acc_len   = 8'd1;
    logic                in_valid  = 1'b0;
    logic                in_ready;
    logic [LANES*PW-1:0] in_data   = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [OW-1:0]       out_data;
    logic                out_sat;

    typedef struct {int data; bit sat; int cyc; bit lat;} res_t;
    typedef struct {bit v; longint s;} beat_t;

    res_t  exp_q[$];
    res_t  obs_q[$];
    beat_t pipe[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    bit    chk_lat = 1'b1;
    int    m_len, m_cnt;
    longint m_acc;
    bit    m_open = 1'b0;

    dsp_acc_tree dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: beat sums take four enabled cycles to reach the group accumulator,
    // which reads acc_len at that moment; finished groups are saturated to 16 bits.
    always @(negedge clk) begin : model
        beat_t  b, t;
        longint s;
        int     v;
        res_t   r;
        if (!rst_n) begin
            m_open = 1'b0;
            pipe.delete();
            repeat (4) pipe.push_back('{1'b0, 64'sd0});
            exp_q.delete();
            obs_q.delete();
        end else if (clear) begin
            m_open = 1'b0;
            pipe.delete();
            repeat (4) pipe.push_back('{1'b0, 64'sd0});
        end else if (in_ready === 1'b1) begin
            t = pipe.pop_front();
            if (t.v) begin
                if (!m_open) begin
                    m_len  = (acc_len == 0) ? 1 : int'(acc_len);
                    m_acc  = t.s;
                    m_cnt  = 1;
                    m_open = 1'b1;
                end else begin
                    m_acc += t.s;
                    m_cnt++;
                end
                if (m_cnt == m_len) begin
                    r.sat  = (m_acc > 32767) || (m_acc < -32768);
                    r.data = (m_acc > 32767) ? 32767 : (m_acc < -32768) ? -32768 : int'(m_acc);
                    r.cyc  = cyc + 1;
                    r.lat  = chk_lat;
                    exp_q.push_back(r);
                    m_open = 1'b0;
                end
            end
            s = 0;
            for (int k = 0; k < LANES; k++) begin
                v = $signed(in_data[k*PW +: PW]);
                s += v;
            end
            b.v = in_valid;
            b.s = s;
            pipe.push_back(b);
        end
        if (rst_n && out_valid && out_ready)
            obs_q.push_back('{$signed(out_data), out_sat, cyc, 1'b0});
    end

    function automatic logic [LANES*PW-1:0] fill(input int v);
        logic [LANES*PW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*PW +: PW] = v[PW-1:0];
        return r;
    endfunction

    function automatic logic [LANES*PW-1:0] rnd();
        logic [LANES*PW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*PW +: PW] = PW'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 300) begin
            tick();
            n++;
        end
        repeat (8) tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        vectors += 2;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        int a;
        int bv[4] = '{-3, 5, 0, 2};
        chk_lat = 1'b1; out_ready = 1'b1;
        acc_len = 8'd1; in_data = fill(1); in_valid = 1'b1; a = cyc;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        acc_len = 8'd4;
        for (int i = 0; i < 4; i++) begin in_data = fill(bv[i]); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        repeat (2) tick();
        acc_len = 8'd8;
        for (int i = 0; i < 8; i++) begin in_data = fill(1023); in_valid = 1'b1; tick(); end
        for (int i = 0; i < 8; i++) begin in_data = fill(-1024); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        wait_drain();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL directed_count: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size()) begin miscompares++; $display("FAIL directed_result %0d: missing, want data=%0d", i, exp_q[i].data); end
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].sat !== exp_q[i].sat || obs_q[i].cyc !== exp_q[i].cyc) begin
                miscompares++;
                $display("FAIL directed_result %0d: got data=%0d sat=%0d cyc=%0d want data=%0d sat=%0d cyc=%0d", i,
                         obs_q[i].data, obs_q[i].sat, obs_q[i].cyc, exp_q[i].data, exp_q[i].sat, exp_q[i].cyc);
            end
        end
        if (obs_q.size() == 4) begin
            vectors += 5;
            if (obs_q[0].data !== 16 || obs_q[0].sat !== 1'b0) begin miscompares++; $display("FAIL len1_ones: got %0d/%0d want 16/0", obs_q[0].data, obs_q[0].sat); end
            if (obs_q[0].cyc !== a + 5) begin miscompares++; $display("FAIL len1_latency: got cycle %0d want %0d", obs_q[0].cyc, a + 5); end
            if (obs_q[1].data !== 64) begin miscompares++; $display("FAIL len4_mixed: got %0d want 64", obs_q[1].data); end
            if (obs_q[2].data !== 32767 || obs_q[2].sat !== 1'b1) begin miscompares++; $display("FAIL sat_pos: got %0d/%0d want 32767/1", obs_q[2].data, obs_q[2].sat); end
            if (obs_q[3].data !== -32768 || obs_q[3].sat !== 1'b1) begin miscompares++; $display("FAIL sat_neg: got %0d/%0d want -32768/1", obs_q[3].data, obs_q[3].sat); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random(input bit backpressure);
        chk_lat = !backpressure;
        for (int i = 0; i < 300; i++) begin
            acc_len   = 8'($urandom_range(0, 5));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? fill($urandom_range(0, 1) ? 1023 : -1024) : rnd();
            out_ready = backpressure ? ($urandom_range(0, 9) < 7) : 1'b1;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL random_count: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size()) begin miscompares++; $display("FAIL random_result %0d: missing, want data=%0d", i, exp_q[i].data); end
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].sat !== exp_q[i].sat || (exp_q[i].lat && obs_q[i].cyc !== exp_q[i].cyc)) begin
                miscompares++;
                $display("FAIL random_result %0d: got data=%0d sat=%0d cyc=%0d want data=%0d sat=%0d cyc=%0d", i,
                         obs_q[i].data, obs_q[i].sat, obs_q[i].cyc, exp_q[i].data, exp_q[i].sat, exp_q[i].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        chk_lat = 1'b0; acc_len = 8'd1;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_data   = rnd();
            out_ready = !(i >= 8 && i <= 10);
            #2;
            if (i >= 8 && i <= 10) begin
                vectors += 2;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid %0d: got %b want 1", i, out_valid); end
                if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready %0d: got %b want 0", i, in_ready); end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stall_count: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size()) begin miscompares++; $display("FAIL stall_result %0d: missing, want data=%0d", i, exp_q[i].data); end
            else if (obs_q[i].data !== exp_q[i].data || obs_q[i].sat !== exp_q[i].sat) begin
                miscompares++;
                $display("FAIL stall_result %0d: got data=%0d sat=%0d want data=%0d sat=%0d", i,
                         obs_q[i].data, obs_q[i].sat, exp_q[i].data, exp_q[i].sat);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clear();
        chk_lat = 1'b1; out_ready = 1'b1; acc_len = 8'd4;
        for (int i = 0; i < 2; i++) begin in_data = fill(1); in_valid = 1'b1; tick(); end
        clear = 1'b1; in_data = fill(7); in_valid = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin in_data = fill(1); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        wait_drain();
        vectors += 2;
        if (obs_q.size() != 1) begin miscompares++; $display("FAIL clear_count: got %0d results want 1", obs_q.size()); end
        else if (obs_q[0].data !== 64 || obs_q[0].sat !== 1'b0) begin miscompares++; $display("FAIL clear_result: got %0d/%0d want 64/0", obs_q[0].data, obs_q[0].sat); end
        if (exp_q.size() != 1 || (obs_q.size() == 1 && obs_q[0].cyc !== exp_q[0].cyc)) begin
            miscompares++;
            $display("FAIL clear_model_latency: got %0d results cycle %0d want 1 at model cycle", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].cyc : -1);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        chk_lat = 1'b1; out_ready = 1'b1; acc_len = 8'd1;
        in_data = fill(1); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_drain();
        vectors++;
        if (obs_q.size() != 1 || obs_q[0].data !== 16) begin miscompares++; $display("FAIL pre_reset_result: got %0d results want one of 16", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
        acc_len = 8'd3;
        for (int i = 0; i < 2; i++) begin in_data = fill(5); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        if (out_data !== '0) begin miscompares++; $display("FAIL midreset_out_data: got %0d want 0", $signed(out_data)); end
        if (out_sat !== 1'b0) begin miscompares++; $display("FAIL midreset_out_sat: got %b want 0", out_sat); end
        repeat (2) tick();
        rst_n = 1'b1;
        acc_len = 8'd2;
        for (int i = 0; i < 2; i++) begin in_data = fill(2); in_valid = 1'b1; tick(); end
        in_valid = 1'b0;
        wait_drain();
        vectors++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin miscompares++; $display("FAIL post_reset_count: got %0d results want 1", obs_q.size()); end
        else if (obs_q[0].data !== 64 || obs_q[0].cyc !== exp_q[0].cyc) begin
            miscompares++;
            $display("FAIL post_reset_result: got %0d at cycle %0d want 64 at cycle %0d", obs_q[0].data, obs_q[0].cyc, exp_q[0].cyc);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1'b0);
        test_random(1'b1);
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
